// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage driving a req/gnt/rvalid data bus; MISALIGN_TRAP_EN makes misaligned accesses trap instead of masking
package primus_core_pkg;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef struct packed {
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    wb_sel_e wb_sel;
  } ctrl_t;
endpackage

module mem_stage
  import primus_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  ctrl_t           ex_ctrl_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic [XLEN-1:0] ex_rs2_data_i,
  input  logic [4:0]      ex_rd_i,
  input  logic [XLEN-1:0] ex_pc4_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic            wb_reg_write_o,
  output wb_sel_e         wb_sel_o,
  output logic [XLEN-1:0] wb_alu_result_o,
  output logic [XLEN-1:0] wb_mem_data_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_pc4_o,
  output logic            wb_misalign_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;
  state_e state, state_n;
  logic mem_op, store, trap, req, done;
  logic [1:0] off, off_q;
  logic [2:0] f3_q;
  logic [15:0] sh;
  logic [XLEN-1:0] ext;
  assign mem_op = ex_valid_i & (ex_ctrl_i.mem_read | ex_ctrl_i.mem_write);
  assign store = ex_ctrl_i.mem_write;
`ifdef MISALIGN_TRAP_EN
  logic mis;
  assign mis = (ex_funct3_i[1:0] == 2'b01 & ex_alu_result_i[0]) |
               (ex_funct3_i[1:0] == 2'b10 & ex_alu_result_i[1:0] != 2'b00);
  assign trap = mem_op & mis;
`else
  assign trap = 1'b0;
`endif
  // low address bits beyond the access size are dropped so misaligned accesses stay in-word
  assign off = ex_funct3_i[1] ? 2'b00 : ex_funct3_i[0] ? {ex_alu_result_i[1], 1'b0} : ex_alu_result_i[1:0];
  assign req = mem_op & !trap & state != WAIT_R;
  assign done = (req & store & dmem_gnt_i) | (state == WAIT_R & dmem_rvalid_i) | trap;
  assign stall_o = mem_op & !done;
  assign dmem_req_o = req;
  assign dmem_we_o = store;
  assign dmem_addr_o = {ex_alu_result_i[XLEN-1:2], 2'b00};
  assign dmem_be_o = (!store | ex_funct3_i[1]) ? 4'b1111 : ex_funct3_i[0] ? 4'b0011 << off : 4'b0001 << off;
  assign dmem_wdata_o = ex_funct3_i[1] ? ex_rs2_data_i :
                        ex_funct3_i[0] ? {(XLEN/16){ex_rs2_data_i[15:0]}} : {(XLEN/8){ex_rs2_data_i[7:0]}};
  assign sh = 16'(dmem_rdata_i >> {off_q, 3'b000});
  assign ext = f3_q[1] ? dmem_rdata_i :
               f3_q[0] ? {{(XLEN-16){sh[15] & ~f3_q[2]}}, sh} : {{(XLEN-8){sh[7] & ~f3_q[2]}}, sh[7:0]};
  always_comb begin
    state_n = state == WAIT_R ? (dmem_rvalid_i ? IDLE : WAIT_R) :
              !req ? IDLE : !dmem_gnt_i ? REQ : store ? IDLE : WAIT_R;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      f3_q <= '0;
      off_q <= '0;
    end else begin
      state <= state_n;
      if (req & dmem_gnt_i) begin
        f3_q <= ex_funct3_i;
        off_q <= off;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_o <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_sel_o <= WB_ALU;
      wb_alu_result_o <= '0;
      wb_mem_data_o <= '0;
      wb_rd_o <= '0;
      wb_pc4_o <= '0;
      wb_misalign_o <= 1'b0;
    end else if (stall_o) begin
      wb_valid_o <= 1'b0;
    end else begin
      wb_valid_o <= ex_valid_i;
      if (ex_valid_i) begin
        wb_reg_write_o <= ex_ctrl_i.reg_write & !trap;
        wb_sel_o <= ex_ctrl_i.wb_sel;
        wb_alu_result_o <= ex_alu_result_i;
        wb_mem_data_o <= state == WAIT_R ? ext : '0;
        wb_rd_o <= ex_rd_i;
        wb_pc4_o <= ex_pc4_i;
        wb_misalign_o <= trap;
      end
    end
  end
endmodule
